dvga_cfg_loader: RTL and testbench
==================================

# dvga_cfg_loader

Synthesizable Wishbone master that programs the DVGA controller's register bank after reset or on software request, replacing the testbench-only configuration master. On `start` it writes a fixed sequence of configuration words to consecutive word addresses starting at `BASEADDR`, using single classic cycles, with per-word error/timeout retry. It sits between the system control logic and the DVGA slave port, normally through the Wishbone interconnect.

## Interface
- `BASEADDR`, 32'h0000_0000, byte address of first DVGA register
- `NWORDS`, 8, number of words written (1..16)
- `MAX_RETRY`, 3, retries per word after err/timeout before failing
- `TIMEOUT`, 255, cycles in S_REQ without ack/err before a timeout (1..255)
- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin sequence; sampled only in S_IDLE or S_FAIL
- `busy`  out  1  high from the cycle after accepted `start` until sequence ends
- `done`  out  1  one-cycle pulse when last word acked
- `fail`  out  1  sticky; set on retry exhaustion, cleared by next accepted `start`
- `wb_adr_o`  out  32  `BASEADDR + 4*index`
- `wb_dat_o`  out  32  config word `index`
- `wb_dat_i`  in  32  unused (writes only)
- `wb_sel_o`  out  4  4'b1111 while `wb_cyc_o`, else 0
- `wb_we_o`, `wb_stb_o`, `wb_cyc_o`  out  1 each  `we`=`stb`=`cyc`
- `wb_cti_o`  out  3  always 3'b000
- `wb_bte_o`  out  2  always 2'b00
- `wb_ack_i`, `wb_err_i`  in  1 each  slave termination

## Operation
- Config words (index 0..7): 20000009, 00010000, 00810000, 00000000, 00000002, 00000000, 00000024, 00000001 (hex); indices ≥8 return 20000009.
- States: S_IDLE, S_REQ, S_GAP, S_FAIL.
- S_IDLE/S_FAIL + `start` -> S_REQ; index=0, retry=0, wait=0, `fail` cleared.
- S_REQ: cyc/stb/we asserted; `wait` increments per cycle.
  - `ack` (priority over `err`): if index==NWORDS-1 -> S_IDLE, `done` pulse; else index++, retry=0 -> S_GAP.
  - `err` or wait==TIMEOUT: if retry==MAX_RETRY -> S_FAIL, `fail`=1; else retry++ -> S_GAP (same index).
- S_GAP: one idle cycle, wait=0 -> S_REQ.
- `start` in S_REQ/S_GAP ignored.
- `busy` = state is S_REQ or S_GAP.
- Counters: index 4 bits, retry 2 bits min (sized from MAX_RETRY), wait 8 bits; no wrap possible within legal parameters.

## Timing
- All outputs registered; reset value 0 for every output (`wb_adr_o`, `wb_dat_o` = 0).
- `start` high at edge N in S_IDLE -> `wb_cyc_o`/`busy` high after edge N, adr=BASEADDR.
- Ack at edge M -> cyc low after M (no back-to-back cycles); next word's cyc high after M+1.
- Minimum sequence: 2*NWORDS-1 bus-visible cycles with zero-wait slave; `done` high the cycle after final ack, coincident with cyc low.
- Timeout fires at edge where wait==TIMEOUT, i.e. TIMEOUT+1 cycles of stb without response.
- `reset` asserted mid-transfer: cyc/stb drop immediately (asynchronous), state S_IDLE, `fail`=0.
- Simultaneous ack and err: treated as ack.

## Structure
- Package `dvga_cfg_pkg`: state enum, word count limit, default config-word constants.
- Sub-module `dvga_cfg_rom`: combinational index -> 32-bit word lookup; loader registers its output into `wb_dat_o`.

## Test plan
- Zero-wait slave, `start` pulse -> 8 writes to 0x0..0x1C with the listed data, `done` one cycle after 8th ack, `fail`=0.
- Slave with 3 wait states on word 2 -> adr 0x8 held stable with data 00810000 until ack; sequence completes.
- Slave asserts err once on word 4 -> word 4 (00000002, adr 0x10) rewritten after one gap cycle; `done` asserted.
- Slave errs permanently on word 1 -> 4 attempts (1 + MAX_RETRY) then `fail`=1, cyc low, `done` never; new `start` clears `fail` and restarts at adr 0x0.
- Silent slave -> cyc held 256 cycles per attempt, `fail` after 4 timeouts.
- `reset` asserted during word 5 -> cyc/stb/busy 0 asynchronously; `start` afterwards restarts from word 0.

Source files
------------

// File: rtl/dvga_cfg_pkg.sv
// Purpose: shared types and constants for the DVGA configuration loader.
//   state_t      - loader FSM states
//   NWORDS_MAX   - largest supported configuration sequence
//   cfg_word()   - default configuration word for a register index
package dvga_cfg_pkg;

  localparam int unsigned NWORDS_MAX = 16;
  localparam int unsigned IDX_W      = $clog2(NWORDS_MAX);
  localparam int unsigned WAIT_W     = 8;
  localparam int unsigned ADR_W      = 32;
  localparam int unsigned DAT_W      = 32;

  // Fill value returned for indices past the programmed table
  localparam logic [DAT_W-1:0] CFG_FILL = 32'h2000_0009;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_GAP  = 2'd2,
    S_FAIL = 2'd3
  } state_t;

  // Default DVGA register image, one word per consecutive register
  function automatic logic [DAT_W-1:0] cfg_word(input logic [IDX_W-1:0] idx);
    case (idx)
      4'd0:    return 32'h2000_0009;
      4'd1:    return 32'h0001_0000;
      4'd2:    return 32'h0081_0000;
      4'd3:    return 32'h0000_0000;
      4'd4:    return 32'h0000_0002;
      4'd5:    return 32'h0000_0000;
      4'd6:    return 32'h0000_0024;
      4'd7:    return 32'h0000_0001;
      default: return CFG_FILL;
    endcase
  endfunction

endpackage

// File: rtl/dvga_cfg_loader_if.sv
// Purpose: Wishbone classic bus between the configuration loader and the DVGA slave.
//   adr, dat_w, sel, we, stb, cyc, cti, bte : master -> slave
//   dat_r, ack, err                          : slave -> master
interface dvga_cfg_loader_if;
  import dvga_cfg_pkg::*;

  logic [ADR_W-1:0] adr;
  logic [DAT_W-1:0] dat_w;
  logic [DAT_W-1:0] dat_r;
  logic [3:0]       sel;
  logic             we;
  logic             stb;
  logic             cyc;
  logic [2:0]       cti;
  logic [1:0]       bte;
  logic             ack;
  logic             err;

  modport master (
    output adr, dat_w, sel, we, stb, cyc, cti, bte,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, sel, we, stb, cyc, cti, bte,
    output dat_r, ack, err
  );

endinterface

// File: rtl/dvga_cfg_rom.sv
// Purpose: combinational lookup of the configuration word for a register index.
//   idx    in  register index
//   word_c out configuration word (combinational)
module dvga_cfg_rom
  import dvga_cfg_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [DAT_W-1:0] word_c
);

  assign word_c = cfg_word(idx);

endmodule

// File: rtl/dvga_cfg_loader.sv
// Purpose: Wishbone master that writes the DVGA register image to consecutive
// word addresses from BASEADDR, one classic single cycle per word, retrying a
// word on err/timeout up to MAX_RETRY times.
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   start  in  begin a sequence (honoured only when idle or failed)
//   busy   out sequence in progress
//   done   out one-cycle pulse after the final word is acked
//   fail   out sticky retry-exhaustion flag, cleared by the next start
//   bus    master modport of the Wishbone bus
module dvga_cfg_loader
  import dvga_cfg_pkg::*;
#(
  parameter logic [ADR_W-1:0] BASEADDR  = 32'h0000_0000,
  parameter int unsigned      NWORDS    = 8,
  parameter int unsigned      MAX_RETRY = 3,
  parameter int unsigned      TIMEOUT   = 255
)(
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                fail,
  dvga_cfg_loader_if.master   bus
);

  localparam int unsigned RETRY_W = (MAX_RETRY < 4) ? 2 : $clog2(MAX_RETRY + 1);

  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(NWORDS - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);
  localparam logic [WAIT_W-1:0]  WAIT_LIM  = WAIT_W'(TIMEOUT);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic [WAIT_W-1:0]  wait_cnt, wait_n;
  logic               done_n;
  logic               fail_n;
  logic               req_n;
  logic               busy_n;
  logic [DAT_W-1:0]   word_c;
  logic               unused_dat;

  // Write-only master: read data is never consumed
  assign unused_dat = ^bus.dat_r;

  assign bus.cti = 3'b000;
  assign bus.bte = 2'b00;

  // Word for the index the next cycle will present, so data is registered with adr
  dvga_cfg_rom u_rom (
    .idx    (idx_n),
    .word_c (word_c)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state, counter and flag logic
  always_comb begin
    state_n = state;
    idx_n   = idx;
    retry_n = retry;
    wait_n  = wait_cnt;
    done_n  = 1'b0;
    fail_n  = fail;
    case (state)
      S_IDLE, S_FAIL: begin
        if (start) begin
          state_n = S_REQ;
          idx_n   = '0;
          retry_n = '0;
          wait_n  = '0;
          fail_n  = 1'b0;
        end
      end
      S_REQ: begin
        wait_n = wait_cnt + 1'b1;
        // ack wins over a simultaneous err
        if (bus.ack) begin
          if (idx == LAST_IDX) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n   = idx + 1'b1;
            retry_n = '0;
            state_n = S_GAP;
          end
        end else if (bus.err || (wait_cnt == WAIT_LIM)) begin
          if (retry == RETRY_LIM) begin
            state_n = S_FAIL;
            fail_n  = 1'b1;
          end else begin
            retry_n = retry + 1'b1;
            state_n = S_GAP;
          end
        end
      end
      S_GAP: begin
        wait_n  = '0;
        state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign req_n  = (state_n == S_REQ);
  assign busy_n = (state_n == S_REQ) || (state_n == S_GAP);

  // Counters and registered outputs; reset drops the bus cycle immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx       <= '0;
      retry     <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      fail      <= 1'b0;
      bus.cyc   <= 1'b0;
      bus.stb   <= 1'b0;
      bus.we    <= 1'b0;
      bus.sel   <= 4'b0000;
      bus.adr   <= '0;
      bus.dat_w <= '0;
    end else begin
      idx       <= idx_n;
      retry     <= retry_n;
      wait_cnt  <= wait_n;
      busy      <= busy_n;
      done      <= done_n;
      fail      <= fail_n;
      bus.cyc   <= req_n;
      bus.stb   <= req_n;
      bus.we    <= req_n;
      bus.sel   <= {4{req_n}};
      bus.adr   <= BASEADDR + (ADR_W'(idx_n) << 2);
      bus.dat_w <= word_c;
    end
  end

endmodule

// File: tb/tb_dvga_cfg_loader.sv
// Purpose: self-checking bench for dvga_cfg_loader. Each run builds a list of
// slave responses per attempt, derives the expected cycle-by-cycle bus trace
// from it, then replays the responses and compares the DUT against the trace.
module tb_dvga_cfg_loader;

  localparam int unsigned NW         = 8;
  localparam int unsigned MAX_RETRY  = 3;
  localparam int unsigned TIMEOUT    = 255;
  localparam int          SILENT_LAT = TIMEOUT + 1;

  localparam int K_ACK  = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_SIL  = 3;

  typedef struct {
    int word;
    int lat;
    int kind;
  } att_t;

  typedef struct {
    bit cyc;
    bit busy;
    bit done;
    bit fail;
    int word;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic busy, done, fail;

  int errs = 0;
  int checks = 0;

  att_t plan[$];
  exp_t trace[$];
  logic [31:0] cfg_tab [16];

  dvga_cfg_loader_if bus ();

  dvga_cfg_loader #(
    .BASEADDR  (32'h0000_0000),
    .NWORDS    (NW),
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .busy  (busy),
    .done  (done),
    .fail  (fail),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Slave response for attempt n of word w under a given scenario
  task automatic pick(input int mode, input int w, input int n, output int kind, output int lat);
    int r;
    kind = K_ACK;
    lat  = 1;
    case (mode)
      1: if (w == 2) lat = 4;
      2: if (w == 4 && n == 0) kind = K_ERR;
      3: if (w == 1) kind = K_ERR;
      4: begin kind = K_SIL; lat = SILENT_LAT; end
      5: begin
        r   = int'($urandom_range(0, 99));
        lat = int'($urandom_range(1, 4));
        if (r < 70)      kind = K_ACK;
        else if (r < 84) kind = K_ERR;
        else if (r < 95) kind = K_BOTH;
        else begin kind = K_SIL; lat = SILENT_LAT; end
      end
      default: ;
    endcase
  endtask

  // Build the attempt plan and the expected trace it implies
  task automatic build(input int mode);
    int  n;
    bit  ok;
    bit  acked;
    att_t a;
    exp_t e;
    plan.delete();
    trace.delete();
    for (int w = 0; w < NW; w++) begin
      n  = 0;
      ok = 1'b0;
      while (!ok && n <= MAX_RETRY) begin
        pick(mode, w, n, a.kind, a.lat);
        a.word = w;
        plan.push_back(a);
        ok = (a.kind == K_ACK) || (a.kind == K_BOTH);
        n++;
      end
      if (!ok) break;
    end
    foreach (plan[i]) begin
      for (int k = 0; k < plan[i].lat; k++) begin
        e = '{1'b1, 1'b1, 1'b0, 1'b0, plan[i].word};
        trace.push_back(e);
      end
      acked = (plan[i].kind == K_ACK) || (plan[i].kind == K_BOTH);
      if (acked && plan[i].word == NW - 1) e = '{1'b0, 1'b0, 1'b1, 1'b0, 0};
      else if (i == plan.size() - 1)       e = '{1'b0, 1'b0, 1'b0, 1'b1, 0};
      else                                 e = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
      trace.push_back(e);
    end
  endtask

  // Start a sequence, replay the plan and compare every cycle to the trace
  task automatic run_seq(input bit noise);
    int   a;
    int   c;
    int   kind;
    exp_t e;
    a = 0;
    c = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    foreach (trace[t]) begin
      e = trace[t];
      chk("cyc",  32'(bus.cyc), 32'(e.cyc));
      chk("stb",  32'(bus.stb), 32'(e.cyc));
      chk("we",   32'(bus.we),  32'(e.cyc));
      chk("sel",  32'(bus.sel), e.cyc ? 32'hf : 32'h0);
      chk("busy", 32'(busy),    32'(e.busy));
      chk("done", 32'(done),    32'(e.done));
      chk("fail", 32'(fail),    32'(e.fail));
      if (e.cyc) begin
        chk("adr", bus.adr,   32'(4 * e.word));
        chk("dat", bus.dat_w, cfg_tab[e.word]);
      end
      bus.ack = 1'b0;
      bus.err = 1'b0;
      if (bus.cyc && a < plan.size()) begin
        c++;
        if (c >= plan[a].lat) begin
          kind    = plan[a].kind;
          bus.ack = (kind == K_ACK) || (kind == K_BOTH);
          bus.err = (kind == K_ERR) || (kind == K_BOTH);
          a++;
          c = 0;
        end
      end
      start = (noise && e.busy) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    bus.ack = 1'b0;
    bus.err = 1'b0;
    start   = 1'b0;
    chk("idle_cyc",  32'(bus.cyc), 32'h0);
    chk("idle_busy", 32'(busy),    32'h0);
    chk("idle_done", 32'(done),    32'h0);
    chk("idle_fail", 32'(fail),    32'(trace[$].fail));
  endtask

  initial begin
    bit found;
    bus.ack   = 1'b0;
    bus.err   = 1'b0;
    bus.dat_r = 32'h0;
    cfg_tab[0] = 32'h2000_0009;
    cfg_tab[1] = 32'h0001_0000;
    cfg_tab[2] = 32'h0081_0000;
    cfg_tab[3] = 32'h0000_0000;
    cfg_tab[4] = 32'h0000_0002;
    cfg_tab[5] = 32'h0000_0000;
    cfg_tab[6] = 32'h0000_0024;
    cfg_tab[7] = 32'h0000_0001;
    for (int i = 8; i < 16; i++) cfg_tab[i] = 32'h2000_0009;

    #12;
    chk("rst_cyc",  32'(bus.cyc), 32'h0);
    chk("rst_stb",  32'(bus.stb), 32'h0);
    chk("rst_sel",  32'(bus.sel), 32'h0);
    chk("rst_adr",  bus.adr,      32'h0);
    chk("rst_dat",  bus.dat_w,    32'h0);
    chk("rst_busy", 32'(busy),    32'h0);
    chk("rst_done", 32'(done),    32'h0);
    chk("rst_fail", 32'(fail),    32'h0);
    chk("cti",      32'(bus.cti), 32'h0);
    chk("bte",      32'(bus.bte), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    build(0); run_seq(1'b0);
    build(1); run_seq(1'b0);
    build(2); run_seq(1'b0);
    build(3); run_seq(1'b0);
    build(0); run_seq(1'b0);
    build(4); run_seq(1'b0);
    build(0); run_seq(1'b0);
    repeat (12) begin
      build(5);
      run_seq(1'b1);
    end

    // Asynchronous reset in the middle of word 5
    build(0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (bus.cyc && bus.adr == 32'h14) found = 1'b1;
      else begin
        bus.ack = bus.cyc;
        @(negedge clk);
      end
    end
    bus.ack = 1'b0;
    chk("rst_reach", 32'(found), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("arst_cyc",  32'(bus.cyc), 32'h0);
    chk("arst_stb",  32'(bus.stb), 32'h0);
    chk("arst_busy", 32'(busy),    32'h0);
    chk("arst_fail", 32'(fail),    32'h0);
    @(negedge clk);
    reset = 1'b0;
    run_seq(1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
